// File: rtl/registrador_pkg.sv
// Opcode encodings shared by the multimode register and anything that drives its modo input.
package registrador_pkg;

    localparam int unsigned MODO_W = 3;

    localparam logic [MODO_W-1:0] MODO_HOLD = 3'b000;
    localparam logic [MODO_W-1:0] MODO_LOAD = 3'b001;
    localparam logic [MODO_W-1:0] MODO_INC  = 3'b010;
    localparam logic [MODO_W-1:0] MODO_DEC  = 3'b011;
    localparam logic [MODO_W-1:0] MODO_SHL  = 3'b100;
    localparam logic [MODO_W-1:0] MODO_SHR  = 3'b101;
    localparam logic [MODO_W-1:0] MODO_ROTL = 3'b110;
    localparam logic [MODO_W-1:0] MODO_CLR  = 3'b111;

endpackage

// File: rtl/celula_bit.sv
// One storage bit with asynchronous active-high reset to a per-bit value and an update enable.
module celula_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic relogio,
    input  logic reinicia,
    input  logic habilita,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge relogio or posedge reinicia) begin
        if (reinicia) begin
            q_q <= RESET_BIT;
        end else if (habilita) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/registrador_multimodo.sv
// WIDTH-bit register with load, count, shift and rotate ops selected by modo, plus a carry-out flag.
module registrador_multimodo
    import registrador_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      STEP        = 1
) (
    input  logic              relogio,
    input  logic              reinicia,
    input  logic              habilita,
    input  logic [MODO_W-1:0] modo,
    input  logic [WIDTH-1:0]  dado,
    input  logic              entrada_serial,
    output logic [WIDTH-1:0]  resultado,
    output logic              transbordo,
    output logic              saida_serial,
    output logic              zero
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] resultado_q, resultado_d;
    logic             transbordo_q, transbordo_d;
    logic [WIDTH:0]   soma;

    assign soma = {1'b0, resultado_q} + {1'b0, STEP_W};

    always_comb begin
        resultado_d  = resultado_q;
        transbordo_d = transbordo_q;
        case (modo)
            MODO_HOLD: ;
            MODO_LOAD: begin
                resultado_d  = dado;
                transbordo_d = 1'b0;
            end
            MODO_INC: begin
                resultado_d  = soma[WIDTH-1:0];
                transbordo_d = soma[WIDTH];
            end
            MODO_DEC: begin
                resultado_d  = resultado_q - STEP_W;
                transbordo_d = (resultado_q < STEP_W);
            end
            MODO_SHL: begin
                resultado_d  = {resultado_q[WIDTH-2:0], entrada_serial};
                transbordo_d = resultado_q[WIDTH-1];
            end
            MODO_SHR: begin
                resultado_d  = {entrada_serial, resultado_q[WIDTH-1:1]};
                transbordo_d = resultado_q[0];
            end
            MODO_ROTL: begin
                resultado_d  = {resultado_q[WIDTH-2:0], resultado_q[WIDTH-1]};
                transbordo_d = resultado_q[WIDTH-1];
            end
            MODO_CLR: begin
                resultado_d  = '0;
                transbordo_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Each bit resets to its own slice of RESET_VALUE.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        celula_bit #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_celula (
            .relogio (relogio),
            .reinicia(reinicia),
            .habilita(habilita),
            .d_i     (resultado_d[i]),
            .q_o     (resultado_q[i])
        );
    end

    always_ff @(posedge relogio or posedge reinicia) begin
        if (reinicia) begin
            transbordo_q <= 1'b0;
        end else if (habilita) begin
            transbordo_q <= transbordo_d;
        end
    end

    assign resultado    = resultado_q;
    assign transbordo   = transbordo_q;
    assign saida_serial = resultado_q[WIDTH-1];
    assign zero         = (resultado_q == '0);

endmodule

// File: tb/tb_registrador_multimodo.sv
// Drives a STEP=1 and a STEP=16 instance in lockstep and checks both against an arithmetic model.
module tb_registrador_multimodo;

    logic       relogio = 1'b0;
    logic       reinicia;
    logic       habilita;
    logic [2:0] modo;
    logic [7:0] dado;
    logic       entrada_serial;

    logic [7:0] res1, res16;
    logic       tr1, tr16, ss1, ss16, z1, z16;

    int checks = 0;
    int failures = 0;

    // Model state: register value and flag for each instance.
    int m_r1, m_t1, m_r16, m_t16;

    registrador_multimodo #(.WIDTH(8), .RESET_VALUE(8'hA5), .STEP(1)) u_dut1 (
        .relogio       (relogio),
        .reinicia      (reinicia),
        .habilita      (habilita),
        .modo          (modo),
        .dado          (dado),
        .entrada_serial(entrada_serial),
        .resultado     (res1),
        .transbordo    (tr1),
        .saida_serial  (ss1),
        .zero          (z1)
    );

    registrador_multimodo #(.WIDTH(8), .RESET_VALUE(8'hA5), .STEP(16)) u_dut16 (
        .relogio       (relogio),
        .reinicia      (reinicia),
        .habilita      (habilita),
        .modo          (modo),
        .dado          (dado),
        .entrada_serial(entrada_serial),
        .resultado     (res16),
        .transbordo    (tr16),
        .saida_serial  (ss16),
        .zero          (z16)
    );

    always #5 relogio = ~relogio;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int op, input int r, input int t, input int st,
                                  input int d, input int s, output int nr, output int nt);
        int tmp;
        nr = r;
        nt = t;
        case (op)
            0: ;
            1: begin nr = d; nt = 0; end
            2: begin tmp = r + st; nr = tmp % 256; nt = (tmp >= 256) ? 1 : 0; end
            3: begin nr = (r - st + 256) % 256; nt = (r < st) ? 1 : 0; end
            4: begin nr = (r * 2 + s) % 256; nt = r / 128; end
            5: begin nr = s * 128 + r / 2; nt = r % 2; end
            6: begin nr = (r * 2) % 256 + r / 128; nt = r / 128; end
            default: begin nr = 0; nt = 0; end
        endcase
    endfunction

    task automatic model_reset();
        m_r1 = 'hA5; m_t1 = 0; m_r16 = 'hA5; m_t16 = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_r1"}, res1, 8'(m_r1));
        chk({tag, "_t1"}, {7'b0, tr1}, 8'(m_t1));
        chk({tag, "_ss1"}, {7'b0, ss1}, 8'(m_r1 / 128));
        chk({tag, "_z1"}, {7'b0, z1}, (m_r1 == 0) ? 8'd1 : 8'd0);
        chk({tag, "_r16"}, res16, 8'(m_r16));
        chk({tag, "_t16"}, {7'b0, tr16}, 8'(m_t16));
        chk({tag, "_ss16"}, {7'b0, ss16}, 8'(m_r16 / 128));
        chk({tag, "_z16"}, {7'b0, z16}, (m_r16 == 0) ? 8'd1 : 8'd0);
    endtask

    // Apply one op across the next rising edge, then check 1 time unit after it.
    task automatic op(input string tag, input logic en, input logic [2:0] md,
                      input logic [7:0] d, input logic s);
        int nr, nt;
        habilita = en;
        modo = md;
        dado = d;
        entrada_serial = s;
        @(posedge relogio);
        if (en) begin
            model(int'(md), m_r1, m_t1, 1, int'(d), int'(s), nr, nt);
            m_r1 = nr; m_t1 = nt;
            model(int'(md), m_r16, m_t16, 16, int'(d), int'(s), nr, nt);
            m_r16 = nr; m_t16 = nt;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        reinicia = 1'b1;
        habilita = 1'b0;
        modo = 3'b000;
        dado = 8'h00;
        entrada_serial = 1'b0;
        model_reset();
        @(posedge relogio);
        #1;
        check_all("reset_state");
        reinicia = 1'b0;

        // 1. mid-cycle reset with an enabled INC pending, then held across two edges
        op("pre_load", 1'b1, 3'b001, 8'h10, 1'b0);
        op("pre_inc", 1'b1, 3'b010, 8'h00, 1'b0);
        #2;
        habilita = 1'b1;
        modo = 3'b010;
        reinicia = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset_val", res1, 8'hA5);
        for (int i = 0; i < 2; i++) begin
            @(posedge relogio);
            #1;
            check_all("reset_held");
        end
        reinicia = 1'b0;

        // 2. wrap on INC and borrow on DEC
        op("t2_load", 1'b1, 3'b001, 8'hFE, 1'b0);
        op("t2_inc1", 1'b1, 3'b010, 8'h00, 1'b0);
        chk("t2_inc1_val", res1, 8'hFF);
        op("t2_inc2", 1'b1, 3'b010, 8'h00, 1'b0);
        chk("t2_wrap_val", res1, 8'h00);
        chk("t2_wrap_t", {7'b0, tr1}, 8'd1);
        chk("t2_wrap_z", {7'b0, z1}, 8'd1);
        op("t2_dec", 1'b1, 3'b011, 8'h00, 1'b0);
        chk("t2_dec_val", res1, 8'hFF);
        chk("t2_dec_t", {7'b0, tr1}, 8'd1);

        // 3. shifts and rotate
        op("t3_load", 1'b1, 3'b001, 8'h81, 1'b0);
        op("t3_shl", 1'b1, 3'b100, 8'h00, 1'b0);
        chk("t3_shl_val", res1, 8'h02);
        op("t3_shr", 1'b1, 3'b101, 8'h00, 1'b1);
        chk("t3_shr_val", res1, 8'h81);
        op("t3_rotl", 1'b1, 3'b110, 8'h00, 1'b0);
        chk("t3_rotl_val", res1, 8'h03);
        chk("t3_rotl_t", {7'b0, tr1}, 8'd1);

        // 4. disabled edges ignore modo
        op("t4_load", 1'b1, 3'b001, 8'h3C, 1'b0);
        op("t4_shl", 1'b1, 3'b100, 8'h00, 1'b0);
        op("t4_dis_inc", 1'b0, 3'b010, 8'h00, 1'b1);
        op("t4_dis_shl", 1'b0, 3'b100, 8'h00, 1'b1);
        op("t4_dis_clr", 1'b0, 3'b111, 8'h00, 1'b1);
        chk("t4_hold_val", res1, 8'h78);

        // 5. STEP=16 instance
        op("t5_load", 1'b1, 3'b001, 8'hF8, 1'b0);
        op("t5_inc", 1'b1, 3'b010, 8'h00, 1'b0);
        chk("t5_inc_val", res16, 8'h08);
        chk("t5_inc_t", {7'b0, tr16}, 8'd1);
        op("t5_dec1", 1'b1, 3'b011, 8'h00, 1'b0);
        chk("t5_dec1_val", res16, 8'hF8);
        op("t5_dec2", 1'b1, 3'b011, 8'h00, 1'b0);
        chk("t5_dec2_val", res16, 8'hE8);
        chk("t5_dec2_t", {7'b0, tr16}, 8'd0);

        // 6. CLR differs from reset value
        op("t6_load", 1'b1, 3'b001, 8'h5A, 1'b0);
        op("t6_clr", 1'b1, 3'b111, 8'h00, 1'b0);
        chk("t6_clr_val", res1, 8'h00);
        chk("t6_clr_z", {7'b0, z1}, 8'd1);
        #2;
        reinicia = 1'b1;
        #1;
        model_reset();
        check_all("t6_reset");
        #1;
        reinicia = 1'b0;

        // Random ops with occasional mid-cycle reset pulses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                #1;
                reinicia = 1'b1;
                #1;
                model_reset();
                check_all("rnd_reset");
                #1;
                reinicia = 1'b0;
            end
            op("rnd", ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
               8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
